// File: rtl/iter_divider_unit.sv
// iter_divider_unit: multi-cycle restoring divider producing quotient (LO) and remainder (HI)
module iter_divider_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] p, q, d, raw;
    logic [WIDTH:0] trial;
    logic sign_q, sign_r, dz, accept;
    assign accept = start && (state == IDLE || state == DONE);
    assign trial = {p, q[WIDTH-1]} - {1'b0, d};
    always_comb begin
        state_nx = state;
        busy = state == RUN || state == FIXUP;
        done = state == DONE;
        unique case (state)
            IDLE:    state_nx = accept ? RUN : IDLE;
            RUN:     state_nx = (cnt == CW'(WIDTH - 1)) ? FIXUP : RUN;
            FIXUP:   state_nx = DONE;
            default: state_nx = accept ? RUN : IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            p <= '0;
            q <= '0;
            d <= '0;
            raw <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dz <= 1'b0;
            quotient <= '0;
            remainder <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            q <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            d <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
            raw <= dividend;
            sign_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r <= is_signed && dividend[WIDTH-1];
            p <= '0;
            cnt <= '0;
            dz <= divisor == '0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            p <= trial[WIDTH] ? {p[WIDTH-2:0], q[WIDTH-1]} : trial[WIDTH-1:0];
            q <= {q[WIDTH-2:0], ~trial[WIDTH]};
        end else if (state == FIXUP) begin
            quotient <= dz ? '1 : (sign_q ? -q : q);
            remainder <= dz ? raw : (sign_r ? -p : p);
            div_by_zero <= dz;
        end
    end
endmodule

// File: tb/tb_iter_divider_unit.sv
// tb_iter_divider_unit: table-driven and scoreboarded checks of iter_divider_unit
module tb_iter_divider_unit;
    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
    } vec_t;

    logic clk = 1'b0;
    logic reset, start, is_signed, busy, done, div_by_zero;
    logic [31:0] dividend, divisor, quotient, remainder;
    int total = 0;
    int passed = 0;
    vec_t sb[$];
    vec_t tbl[10];

    iter_divider_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v.s = s; v.a = a; v.b = b; v.ez = 1'b0;
        if (b == 0) begin
            v.eq = '1; v.er = a; v.ez = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            v.eq = 32'h8000_0000; v.er = 0;
        end else if (s) begin
            v.eq = $signed(a) / $signed(b); v.er = $signed(a) % $signed(b);
        end else begin
            v.eq = a / b; v.er = a % b;
        end
        return v;
    endfunction

    task automatic start_op(input vec_t v);
        is_signed = v.s; dividend = v.a; divisor = v.b; start = 1'b1;
        sb.push_back(v);
        tick();
        start = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int n0);
        vec_t e;
        int n = n0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("latency", n, 34);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("quotient", quotient, e.eq);
            check("remainder", remainder, e.er);
            check("div_by_zero", 32'(div_by_zero), 32'(e.ez));
        end
    endtask

    initial begin
        tbl[0] = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        tbl[1] = '{1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        tbl[2] = '{1'b1, 32'd7, -32'sd2, 32'hFFFF_FFFD, 32'd1, 1'b0};
        tbl[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0};
        tbl[4] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};
        tbl[5] = '{1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1};
        tbl[6] = '{1'b1, -32'sd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1};
        tbl[7] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
        tbl[8] = '{1'b1, -32'sd100, -32'sd7, 32'd14, 32'hFFFF_FFFE, 1'b0};
        tbl[9] = '{1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0};
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = 0; divisor = 0;
        repeat (2) tick();
        reset = 1'b0;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dz", 32'(div_by_zero), 0);
        for (int i = 0; i < 10; i++) begin
            start_op(tbl[i]);
            wait_done(1);
            tick();
            check("done_pulse", 32'(done), 0);
        end
        for (int i = 0; i < 6; i++) begin
            start_op(model(1'(i & 1), $urandom, 32'($urandom_range(1, 1 << (i * 5)))));
            wait_done(1);
        end
        start_op(tbl[0]);
        repeat (3) tick();
        is_signed = 1'b1; dividend = 32'd999; divisor = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        dividend = 32'd12345; divisor = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20);
        start_op(tbl[8]);
        check("b2b_done_drop", 32'(done), 0);
        check("b2b_held_q", quotient, 32'd14);
        check("b2b_held_r", remainder, 32'd2);
        wait_done(1);
        tick();
        start_op(tbl[2]);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sb.pop_back());
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dz", 32'(div_by_zero), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
